// File: rtl/ip_call_stack_unit.sv
// ip_call_stack_unit: instruction pointer with step/jump/call/return and a LIFO return-address stack
module ip_call_stack_unit #(
    parameter int WIDTH       = 32,
    parameter int STACK_DEPTH = 8,
    parameter int STEP        = 4,
    parameter int RESET_ADDR  = 0,
    localparam int DW         = $clog2(STACK_DEPTH + 1),
    localparam int AW         = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1
) (
    input  logic             clk,
    input  logic             resetEnable,
    output logic [WIDTH-1:0] out,
    input  logic [WIDTH-1:0] adjust,
    input  logic             stepEnable,
    input  logic             updateEnable,
    input  logic             setEnable,
    input  logic             callEnable,
    input  logic             returnEnable,
    input  logic             clearErrors,
    output logic [DW-1:0]    depth,
    output logic             stackFull,
    output logic             stackEmpty,
    output logic             overflowError,
    output logic             underflowError
);
    logic [WIDTH-1:0] stack_q [STACK_DEPTH];
    logic [WIDTH-1:0] out_q, out_d, ret_addr;
    logic [DW-1:0]    depth_q, depth_d, top_idx;
    logic             ovf_q, ovf_d, unf_q, unf_d, push;
    logic             full, empty;

    assign full     = depth_q == DW'(STACK_DEPTH);
    assign empty    = depth_q == '0;
    assign top_idx  = depth_q - DW'(1);
    assign ret_addr = out_q + WIDTH'(STEP);

    // One action per cycle; a new error wins over a same-cycle clearErrors.
    always_comb begin
        out_d   = out_q;
        depth_d = depth_q;
        ovf_d   = ovf_q & ~clearErrors;
        unf_d   = unf_q & ~clearErrors;
        push    = 1'b0;
        if (returnEnable) begin
            if (empty) begin
                unf_d = 1'b1;
            end else begin
                out_d   = stack_q[top_idx[AW-1:0]];
                depth_d = top_idx;
            end
        end else if (callEnable) begin
            if (full) begin
                ovf_d = 1'b1;
            end else begin
                push    = 1'b1;
                out_d   = adjust;
                depth_d = depth_q + DW'(1);
            end
        end else if (updateEnable) begin
            out_d = out_q + adjust;
        end else if (setEnable) begin
            out_d = adjust;
        end else if (stepEnable) begin
            out_d = ret_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (resetEnable) begin
            out_q   <= WIDTH'(RESET_ADDR);
            depth_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            out_q   <= out_d;
            depth_q <= depth_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !resetEnable)
            stack_q[depth_q[AW-1:0]] <= ret_addr;
    end

    assign out            = out_q;
    assign depth          = depth_q;
    assign stackFull      = full;
    assign stackEmpty     = empty;
    assign overflowError  = ovf_q;
    assign underflowError = unf_q;
endmodule
